// File: rtl/alu_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_cmd_sequencer                                            |
// | Description : Buffers ALU commands, issues one at a time with a single     |
// |               alu_enable pulse, returns results on a response stream.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_cmd_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             gated_clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             alu_enable,
  output logic [2:0]       alu_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t         r_state;
  logic [2:0]     r_mem_op [DEPTH];
  logic [W-1:0]   r_mem_a  [DEPTH];
  logic [W-1:0]   r_mem_b  [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic w_push;
  logic w_pop;
  logic w_nonempty;

  assign cmd_ready  = (r_count < c_depth);
  assign w_nonempty = (r_count != '0);
  assign w_push     = cmd_valid && cmd_ready;
  // The head is popped only at the moment the FSM issues it to the ALU.
  assign w_pop      = w_nonempty && ((r_state == IDLE) || (r_state == RESP && rsp_ready));
  assign busy       = w_nonempty || (r_state != IDLE);

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_op[i] <= '0;
        r_mem_a[i]  <= '0;
        r_mem_b[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_op[r_wr_ptr] <= cmd_op;
        r_mem_a[r_wr_ptr]  <= cmd_a;
        r_mem_b[r_wr_ptr]  <= cmd_b;
        r_wr_ptr           <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      alu_enable <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_op     <= '0;
      ops_done   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            alu_enable <= 1'b1;
            alu_op     <= r_mem_op[r_rd_ptr];
            alu_a      <= r_mem_a[r_rd_ptr];
            alu_b      <= r_mem_b[r_rd_ptr];
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          alu_enable <= 1'b0;
          r_state    <= CAPTURE;
        end
        CAPTURE: begin
          // Zero flag derived locally; the ALU's own flag lags one operation.
          rsp_result <= alu_result;
          rsp_zero   <= (alu_result == '0);
          rsp_op     <= alu_op;
          rsp_valid  <= 1'b1;
          r_state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            if (w_pop) begin
              alu_enable <= 1'b1;
              alu_op     <= r_mem_op[r_rd_ptr];
              alu_a      <= r_mem_a[r_rd_ptr];
              alu_b      <= r_mem_b[r_rd_ptr];
              r_state    <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_cmd_sequencer                                         |
// | Description : Directed bench for alu_cmd_sequencer with a behavioural ALU. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_cmd_sequencer;

  logic        gated_clk = 1'b0;
  logic        reset     = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_a, cmd_b;
  logic        alu_enable, rsp_valid, rsp_zero, busy;
  logic [2:0]  alu_op, rsp_op;
  logic [3:0]  alu_a, alu_b, alu_result, rsp_result;
  logic [15:0] ops_done;

  // Narrow-counter copy fed with identical stimulus
  logic        cmd_ready2, alu_enable2, rsp_valid2, rsp_zero2, busy2;
  logic [2:0]  alu_op2, rsp_op2;
  logic [3:0]  alu_a2, alu_b2, rsp_result2;
  logic [1:0]  ops_done2;

  int checks   = 0;
  int failures = 0;

  always #5 gated_clk = ~gated_clk;

  alu_cmd_sequencer #(.W(4), .DEPTH(4), .CNT_W(16)) u_dut (
    .gated_clk(gated_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_enable(alu_enable), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_op(rsp_op), .busy(busy), .ops_done(ops_done)
  );

  alu_cmd_sequencer #(.W(4), .DEPTH(4), .CNT_W(2)) u_dut2 (
    .gated_clk(gated_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_enable(alu_enable2), .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(alu_result),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2), .rsp_zero(rsp_zero2),
    .rsp_op(rsp_op2), .busy(busy2), .ops_done(ops_done2)
  );

  // Behavioural clock-gated ALU: result register loads only when enabled
  always_ff @(posedge gated_clk or posedge reset) begin
    if (reset) alu_result <= '0;
    else if (alu_enable) begin
      case (alu_op)
        3'b000:  alu_result <= alu_a + alu_b;
        3'b001:  alu_result <= alu_a - alu_b;
        3'b010:  alu_result <= alu_a & alu_b;
        3'b011:  alu_result <= alu_a | alu_b;
        3'b100:  alu_result <= ~alu_a;
        3'b101:  alu_result <= alu_a ^ alu_b;
        3'b110:  alu_result <= alu_a << 1;
        default: alu_result <= alu_a >> 1;
      endcase
    end
  end

  logic prev_en = 1'b0;
  always @(negedge gated_clk) begin
    if (!reset) begin
      checks++;
      assert (!(prev_en && alu_enable)) else begin
        failures++;
        $error("FAIL alu_enable_back_to_back observed=1 expected=0");
      end
    end
    prev_en = alu_enable;
  end

  task automatic tick;
    @(posedge gated_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk(tag, rsp_valid, 1);
  endtask

  initial begin
    logic bad;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 1;
    tick; tick;
    reset = 0;
    tick;

    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_ops_done", ops_done, 0);

    // Single ADD 5+3
    cmd_valid = 1; cmd_op = 3'b000; cmd_a = 4'h5; cmd_b = 4'h3;
    tick;
    cmd_valid = 0;
    chk("add_en_c0", alu_enable, 0);
    chk("add_busy", busy, 1);
    tick;
    chk("add_en_c1", alu_enable, 1);
    chk("add_alu_a", alu_a, 5);
    tick;
    chk("add_en_c2", alu_enable, 0);
    chk("add_valid_c2", rsp_valid, 0);
    tick;
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 4'h8);
    chk("add_zero", rsp_zero, 0);
    chk("add_op", rsp_op, 3'b000);
    tick;
    chk("add_valid_clr", rsp_valid, 0);
    chk("add_ops_done", ops_done, 1);
    chk("add_ops_done2", ops_done2, 1);
    chk("add_idle_busy", busy, 0);

    // SUB wrap then NOT to zero, back-to-back
    cmd_valid = 1; cmd_op = 3'b001; cmd_a = 4'h3; cmd_b = 4'h5;
    tick;
    cmd_op = 3'b100; cmd_a = 4'hF; cmd_b = 4'h0;
    tick;
    cmd_valid = 0;
    chk("sub_en", alu_enable, 1);
    chk("sub_alu_op", alu_op, 3'b001);
    tick; tick;
    chk("sub_valid", rsp_valid, 1);
    chk("sub_result", rsp_result, 4'hE);
    chk("sub_zero", rsp_zero, 0);
    chk("sub_op", rsp_op, 3'b001);
    tick;
    chk("not_issue_en", alu_enable, 1);
    chk("not_issue_valid", rsp_valid, 0);
    chk("sub_ops_done", ops_done, 2);
    chk("sub_ops_done2", ops_done2, 2);
    tick; tick;
    chk("not_valid", rsp_valid, 1);
    chk("not_result", rsp_result, 4'h0);
    chk("not_zero", rsp_zero, 1);
    chk("not_op", rsp_op, 3'b100);
    tick;
    chk("not_ops_done", ops_done, 3);
    chk("not_ops_done2", ops_done2, 3);
    chk("not_busy", busy, 0);

    // FIFO fill under backpressure: ADD i+1 for i=1..6
    rsp_ready = 0; cmd_valid = 1; cmd_op = 3'b000; cmd_b = 4'h1;
    for (int i = 1; i <= 5; i++) begin
      cmd_a = 4'(i);
      tick;
    end
    cmd_a = 4'h6;
    chk("full_ready", cmd_ready, 0);
    tick;
    chk("full_ready_hold", cmd_ready, 0);
    chk("full_head_valid", rsp_valid, 1);
    chk("full_head_result", rsp_result, 4'h2);
    cmd_valid = 0; rsp_ready = 1;
    tick;
    chk("full_ready_after_pop", cmd_ready, 1);
    chk("full_ops_done_4", ops_done, 4);
    chk("wrap_ops_done2_0", ops_done2, 0);
    for (int k = 2; k <= 5; k++) begin
      wait_rsp("full_wait_rsp");
      chk("full_order_result", rsp_result, 32'(k + 1));
      tick;
      chk("full_ops_done", ops_done, 32'(3 + k));
      chk("wrap_ops_done2", ops_done2, 32'((3 + k) % 4));
    end
    chk("full_busy_end", busy, 0);

    // Response stall with a queued command behind it
    rsp_ready = 0; cmd_valid = 1; cmd_op = 3'b110; cmd_a = 4'h9; cmd_b = 4'h0;
    tick;
    cmd_op = 3'b000; cmd_a = 4'h7; cmd_b = 4'h7;
    tick;
    cmd_valid = 0;
    wait_rsp("stall_wait_rsp");
    chk("shl_result", rsp_result, 4'h2);
    chk("shl_op", rsp_op, 3'b110);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'h2 || alu_enable !== 1'b0 || busy !== 1'b1) bad = 1;
    end
    chk("stall_hold", bad, 0);
    rsp_ready = 1;
    tick;
    chk("stall_release_en", alu_enable, 1);
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_ops_done", ops_done, 9);
    wait_rsp("stall_second_rsp");
    chk("stall_second_result", rsp_result, 4'hE);
    tick;
    chk("stall_ops_done2", ops_done, 10);

    // Reset while in CAPTURE with two commands queued
    cmd_valid = 1; cmd_op = 3'b000; cmd_a = 4'h1; cmd_b = 4'h2;
    tick;
    cmd_a = 4'h3; cmd_b = 4'h3;
    tick;
    cmd_a = 4'h5; cmd_b = 4'h5;
    tick;
    cmd_valid = 0;
    chk("pre_rst_alu_a", alu_a, 4'h1);
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_en", alu_enable, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_ops_done", ops_done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    tick;
    reset = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rsp_valid !== 1'b0 || alu_enable !== 1'b0) bad = 1;
    end
    chk("post_rst_quiet", bad, 0);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side counterpart of the clock-gated 4-bit ALU. Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. Issues one command at a time to the ALU with a single-cycle alu_enable pulse, captures the result, recomputes the zero flag from the captured value, and returns it on a valid/ready response stream. alu_enable is held low whenever no command is in flight, so the ALU's clock stays gated off while idle.

Parameters:
W, 4, operand/result width; must match the ALU width
DEPTH, 4, command FIFO entries; power of two, minimum 2
CNT_W, 16, width of the completed-operation counter

Ports:
gated_clk  in  1  block clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_op  in  3  ALU opcode (ALU encoding 000..111)
cmd_a  in  W  operand A
cmd_b  in  W  operand B
alu_enable  out  1  registered ALU clock-gate enable
alu_op  out  3  registered opcode to ALU
alu_a  out  W  registered operand A to ALU
alu_b  out  W  registered operand B to ALU
alu_result  in  W  ALU result register
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  W  captured result
rsp_zero  out  1  1 when rsp_result == 0
rsp_op  out  3  opcode that produced rsp_result
busy  out  1  FIFO non-empty or FSM not IDLE
ops_done  out  CNT_W  completed responses, wraps to 0

Behaviour:
- Reset (async, all registers): FIFO emptied and queued commands discarded; state IDLE; alu_enable=0; alu_op/alu_a/alu_b=0; rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_op=0; ops_done=0. busy is combinational and reads 0. A reset during ISSUE or CAPTURE abandons the in-flight command. The ALU is reset by the same signal.
- FIFO: cmd_ready = (count < DEPTH), combinational from count only. A push occurs on cmd_valid && cmd_ready. Read/write pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, cmd_ready=0, even if a pop occurs that cycle.
  - Commands leave the FIFO in arrival order.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if FIFO non-empty, pop the head; load alu_op/alu_a/alu_b; set alu_enable=1; go to ISSUE. Otherwise stay in IDLE with alu_enable=0.
  - ISSUE (exactly 1 cycle): alu_enable=1 and operands are stable for the whole cycle, so the ALU samples at the closing edge. At that edge, alu_enable goes to 0 and the FSM goes to CAPTURE.
  - CAPTURE (1 cycle): at the closing edge, load rsp_result=alu_result, rsp_zero=(alu_result==0), rsp_op=alu_op; set rsp_valid=1; go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: clear rsp_valid and increment ops_done (wraps at 2^CNT_W). If the FIFO is non-empty, pop and go directly to ISSUE, exactly as in IDLE. Otherwise go to IDLE.
- Latency: with an empty FIFO in IDLE, a command accepted at edge 0 gives rsp_valid=1 after edge 3. Throughput is one command per 3 cycles with rsp_ready held high.
- Zero flag: rsp_zero is computed by this block from the captured result. It must not depend on the ALU's zero output, which lags by one operation.
- alu_enable is never 1 outside ISSUE and never asserted for two consecutive cycles.
- alu_op/alu_a/alu_b hold their last issued values when idle.
- Arithmetic is performed only by the ALU. This block does no width extension; results are W bits, and ADD/SUB wrap mod 2^W.

Test Plan:
- Single ADD, W=4: cmd op=000, a=5, b=3 at edge 0, rsp_ready=1 -> alu_enable high only in cycle 1; rsp_valid after edge 3 with rsp_result=8, rsp_zero=0, rsp_op=000; ops_done=1.
- SUB wrap and NOT to zero: (001, a=3, b=5) then (100, a=0xF, b=0) back-to-back -> responses 0xE/zero=0, then 0x0/zero=1, in order, 3 cycles apart.
- FIFO full/backpressure: rsp_ready=0, push 6 commands continuously -> 1 command goes in flight, 4 are buffered, cmd_ready=0 from then on; release rsp_ready -> 5 responses in order, cmd_ready returns 1 after the first pop.
- Response stall: shift-left (110, a=0x9) with rsp_ready low for 5 cycles -> rsp_result=0x2 held stable and rsp_valid held high; no alu_enable pulse during the stall even with the FIFO non-empty.
- Reset mid-operation: assert reset while in CAPTURE with 2 commands queued -> all outputs at reset values immediately; after release, no responses appear and busy=0.
- Counter wrap: CNT_W=2, complete 5 commands -> ops_done reads 1, 2, 3, 0, 1.
